// File: rtl/axis_axi_wr_master.sv
// Stream-to-memory write engine: takes (address, word count) commands plus an AXI-Stream
// and issues 4 KB-safe INCR bursts on an AXI4 write channel, one burst outstanding at a time.
module axis_axi_wr_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int LEN_WIDTH     = 4,
  parameter int MAX_BURST_LEN = 16,
  parameter int CNT_WIDTH     = 16,
  parameter int AXI_ID        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [LEN_WIDTH-1:0]  m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [1:0]            m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int SIZE      = $clog2(STRB_WIDTH);
  localparam int PAGE_BITS = (ADDR_WIDTH < 12) ? ADDR_WIDTH : 12;
  localparam int BEAT_W    = LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FINISH} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]  r_remain;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_error;

  logic [31:0] w_pageOff;
  logic [31:0] w_toBoundary;
  logic [31:0] w_n;
  logic        w_unusedBid;

  // Burst size: remaining words, capped by the max burst and by the words left before the
  // page boundary (the page shrinks to the whole address space for narrow addresses).
  always_comb begin
    w_pageOff    = 32'(r_addr) & ((32'd1 << PAGE_BITS) - 32'd1);
    w_toBoundary = ((32'd1 << PAGE_BITS) - w_pageOff) >> SIZE;
    w_n          = 32'(r_remain);
    if (w_n > 32'(MAX_BURST_LEN)) w_n = 32'(MAX_BURST_LEN);
    if (w_n > w_toBoundary)       w_n = w_toBoundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_beat   <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_addr   <= cmd_addr & ALIGN_MASK;
          r_remain <= cmd_len;
          r_error  <= 1'b0;
        end
        ADDR: if (m_axi_awready) begin
          r_beat   <= BEAT_W'(w_n);
          r_remain <= r_remain - CNT_WIDTH'(w_n);
          r_addr   <= r_addr + ADDR_WIDTH'(w_n << SIZE);
        end
        DATA: if (s_axis_tvalid && m_axi_wready) r_beat <= r_beat - BEAT_W'(1);
        RESP: if (m_axi_bvalid && (m_axi_bresp != 2'b00)) r_error <= 1'b1;
        default: ;
      endcase
    end
  end

  // The W channel is a straight wire to the stream only while a burst is in flight,
  // so early stream words simply wait with tready low.
  always_comb begin
    w_nextState   = r_state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    s_axis_tready = 1'b0;
    m_axi_bready  = 1'b0;
    done          = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && !rst) w_nextState = (cmd_len == '0) ? FINISH : ADDR;
      end
      ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_nextState = DATA;
      end
      DATA: begin
        m_axi_wvalid  = s_axis_tvalid;
        s_axis_tready = m_axi_wready;
        m_axi_wlast   = (r_beat == BEAT_W'(1));
        if (s_axis_tvalid && m_axi_wready && (r_beat == BEAT_W'(1))) w_nextState = RESP;
      end
      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) w_nextState = (r_remain != '0) ? ADDR : FINISH;
      end
      FINISH: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign busy          = (r_state != IDLE);
  assign error         = r_error;
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = LEN_WIDTH'(w_n - 32'd1);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign w_unusedBid   = ^m_axi_bid;

endmodule

// File: tb/tb_axis_axi_wr_master.sv
// Directed bench for axis_axi_wr_master: stream source and AXI4 slave model with a
// scoreboard of expected bursts and data words.
module tb_axis_axi_wr_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        busy, done, error;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [3:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst, m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [7:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  typedef struct packed {logic [15:0] addr; logic [3:0] len;} awExp_t;
  typedef struct packed {logic [13:0] widx; logic [31:0] data;} wExp_t;

  awExp_t      expAwQ[$];
  wExp_t       expWQ[$];
  logic [31:0] streamQ[$];
  logic [31:0] mem [0:16383];

  int total = 0, bad = 0, cycle = 0;
  int awWait = 0, awDelay = 0, bWait = 0, bDelay = 0, injectIdx = -1;
  int bCount = 0, wBeats = 0, doneCount = 0, awvalidCycles = 0, lastBCycle = 0, breadyDue = -1;
  int burstLen = 0, burstBeat = 0;
  bit gapMode = 0, wStall = 0, burstActive = 0, respPending = 0, lastSHs = 0;
  logic [15:0] burstAddr = '0;
  logic [13:0] wIdx;
  wExp_t       wHead;

  axis_axi_wr_master dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .busy(busy), .done(done), .error(error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expectAw(input logic [15:0] a, input logic [3:0] l);
    expAwQ.push_back({a, l});
  endtask

  // Stream source and AXI slave: inputs change on the falling edge, and the handshakes
  // that the next rising edge will complete are judged once everything has settled.
  always @(negedge clk) begin
    cycle++;
    if (!(s_axis_tvalid && !lastSHs)) begin
      if (streamQ.size() > 0 && (!gapMode || $urandom_range(0, 2) != 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = streamQ[0];
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
    m_axi_awready = m_axi_awvalid && (awWait >= awDelay);
    if (m_axi_awvalid && !m_axi_awready) awWait++;
    m_axi_wready = wStall ? ($urandom_range(0, 3) != 0) : 1'b1;
    m_axi_bvalid = respPending && (bWait >= bDelay);
    if (respPending && !m_axi_bvalid) bWait++;
    m_axi_bresp = (bCount == injectIdx) ? 2'b10 : 2'b00;
    #1;
    if (rst) begin
      burstActive = 0; respPending = 0; awWait = 0; bWait = 0; lastSHs = 0; breadyDue = -1;
      s_axis_tvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    end else begin
      if (m_axi_awvalid) begin
        awvalidCycles++;
        checkOutput("awvalid_expected", m_axi_awvalid, expAwQ.size() != 0);
        if (expAwQ.size() != 0) begin
          checkOutput("awaddr", m_axi_awaddr, expAwQ[0].addr);
          checkOutput("awlen", m_axi_awlen, expAwQ[0].len);
          checkOutput("aw_const",
            {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos},
            {8'h00, 3'd2, 2'b01, 2'b00, 4'b0011, 3'b000, 4'h0});
        end
        if (m_axi_awready) begin
          burstAddr = m_axi_awaddr; burstLen = int'(m_axi_awlen) + 1; burstBeat = 0;
          burstActive = 1; awWait = 0;
          if (expAwQ.size() != 0) void'(expAwQ.pop_front());
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        checkOutput("w_expected", m_axi_wvalid, burstActive && expWQ.size() != 0);
        if (burstActive && expWQ.size() != 0) begin
          wHead = expWQ.pop_front();
          wIdx  = 14'(burstAddr >> 2) + 14'(burstBeat);
          checkOutput("w_addr", wIdx, wHead.widx);
          checkOutput("wdata", m_axi_wdata, wHead.data);
          checkOutput("wlast", m_axi_wlast, burstBeat == burstLen - 1);
          checkOutput("wstrb", m_axi_wstrb, 4'hF);
          mem[wIdx] = m_axi_wdata;
        end
        burstBeat++; wBeats++;
        if (burstBeat == burstLen) begin
          burstActive = 0; respPending = 1; bWait = 0; breadyDue = cycle + 1;
        end
      end
      if (cycle == breadyDue) checkOutput("bready_timing", m_axi_bready, 1'b1);
      if (m_axi_bready) checkOutput("bready_in_resp", m_axi_bready, respPending);
      if (m_axi_bvalid && m_axi_bready) begin
        respPending = 0; bCount++; lastBCycle = cycle;
      end
      if (done) doneCount++;
      lastSHs = s_axis_tvalid && s_axis_tready;
      if (lastSHs && streamQ.size() != 0) void'(streamQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input int len, input int tag);
    logic [15:0] base;
    logic [31:0] d;
    bit accepted;
    base = a & 16'hFFFC;
    for (int i = 0; i < len; i++) begin
      d = {8'hD0, 8'(tag), 16'(i)};
      streamQ.push_back(d);
      expWQ.push_back({14'(base >> 2) + 14'(i), d});
    end
    @(negedge clk);
    cmd_addr = a; cmd_len = 16'(len); cmd_valid = 1'b1;
    accepted = 0;
    for (int k = 0; k < 100; k++) begin
      #2;
      if (cmd_ready === 1'b1) begin accepted = 1; break; end
      @(negedge clk);
    end
    checkOutput("cmd_accepted", accepted, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    checkOutput("busy_after_accept", busy, 1'b1);
    checkOutput("awvalid_after_accept", m_axi_awvalid, len != 0);
    checkOutput("done_after_accept", done, len == 0);
    checkOutput("error_cleared", error, 1'b0);
  endtask

  task automatic runTransfer(input logic [15:0] a, input int len, input int tag, input int expBursts);
    int doneBefore, bBefore, doneCyc;
    bit seen;
    doneBefore = doneCount; bBefore = bCount;
    applyStimulus(a, len, tag);
    seen = (done === 1'b1); doneCyc = cycle;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk); #2;
      if (done === 1'b1) begin seen = 1; doneCyc = cycle; end
    end
    checkOutput("done_seen", seen, 1'b1);
    if (len != 0) checkOutput("done_after_b", doneCyc, lastBCycle + 1);
    checkOutput("b_count", bCount - bBefore, expBursts);
    @(negedge clk); #2;
    checkOutput("done_pulses", doneCount - doneBefore, 1);
    checkOutput("idle_after_done", {busy, cmd_ready, done}, 3'b010);
    checkOutput("queues_drained", expAwQ.size() + expWQ.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, awBefore;
    bit reached;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_outputs",
      {cmd_ready, m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready, busy, done, error}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("cmd_ready_after_reset", cmd_ready, 1'b1);

    $display("[TB] single burst");
    expectAw(16'h0100, 4'd3);
    runTransfer(16'h0100, 4, 1, 1);
    for (int i = 0; i < 4; i++) checkOutput("mem_single", mem[16'h40 + i], {8'hD0, 8'd1, 16'(i)});

    $display("[TB] multi burst");
    base = wBeats;
    expectAw(16'h0000, 4'd15); expectAw(16'h0040, 4'd15); expectAw(16'h0080, 4'd7);
    runTransfer(16'h0000, 40, 2, 3);
    checkOutput("multi_beats", wBeats - base, 40);

    $display("[TB] 4KB split");
    expectAw(16'h0FF8, 4'd1); expectAw(16'h1000, 4'd5);
    runTransfer(16'h0FF8, 8, 3, 2);

    $display("[TB] backpressure");
    gapMode = 1; wStall = 1; awDelay = 3; bDelay = 5;
    base = wBeats;
    expectAw(16'h2004, 4'd15); expectAw(16'h2044, 4'd3);
    runTransfer(16'h2007, 20, 4, 2);
    checkOutput("bp_beats", wBeats - base, 20);
    gapMode = 0; wStall = 0; awDelay = 0; bDelay = 0;

    $display("[TB] zero length");
    awBefore = awvalidCycles;
    runTransfer(16'h0300, 0, 5, 0);
    checkOutput("zero_no_aw", awvalidCycles - awBefore, 0);

    $display("[TB] error response");
    injectIdx = bCount + 1;
    expectAw(16'h0500, 4'd15); expectAw(16'h0540, 4'd3);
    runTransfer(16'h0500, 20, 6, 2);
    checkOutput("error_set", error, 1'b1);
    injectIdx = -1;
    expectAw(16'h0600, 4'd0);
    runTransfer(16'h0600, 1, 7, 1);
    checkOutput("error_stays_clear", error, 1'b0);

    $display("[TB] reset mid-burst");
    base = wBeats;
    expectAw(16'h0800, 4'd7);
    applyStimulus(16'h0800, 8, 8);
    reached = 0;
    for (int k = 0; k < 200 && !reached; k++) begin
      @(negedge clk); #2;
      if (wBeats - base >= 2) reached = 1;
    end
    checkOutput("two_beats_reached", reached, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    streamQ.delete(); expAwQ.delete(); expWQ.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("outputs_after_midreset",
      {m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready, busy, done, error}, 7'h00);
    checkOutput("cmd_ready_after_midreset", cmd_ready, 1'b1);
    checkOutput("beats_abandoned", wBeats - base, 2);
    expectAw(16'h0900, 4'd2);
    runTransfer(16'h0900, 3, 9, 1);
    for (int i = 0; i < 3; i++) checkOutput("mem_after_reset", mem[16'h240 + i], {8'hD0, 8'd9, 16'(i)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_axi_wr_master.md
# axis_axi_wr_master

Stream-to-memory write engine that sits directly upstream of the AXI4 RAM slave. It accepts a command (start address, length in words) and then an AXI-Stream of data words, and issues INCR write bursts on an AXI4 master write channel (AW/W/B). Bursts are sized to the remaining length, capped by a maximum burst length, and never cross a 4 KB boundary. Completion is reported with a one-cycle `done` pulse and a sticky error flag.

## Interface
- DATA_WIDTH, 32: AXI/stream data width in bits.
- ADDR_WIDTH, 16: AXI address width in bits.
- STRB_WIDTH, DATA_WIDTH/8: bytes per word; power of two.
- ID_WIDTH, 8: AXI ID width.
- LEN_WIDTH, 4: awlen width.
- MAX_BURST_LEN, 16: beats per burst cap; ≤ 2**LEN_WIDTH.
- CNT_WIDTH, 16: command length width, in words.
- AXI_ID, 0: constant awid.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (treated as 0).
- cmd_len  in  CNT_WIDTH  number of words.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- s_axis_tdata  in  DATA_WIDTH  write data.
- s_axis_tvalid / s_axis_tready  in / out  1  data handshake.
- busy  out  1  high from command accept until `done`.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky; set on any bresp ≠ 00.
- m_axi_awid / awaddr / awlen / awsize / awburst  out  ID_WIDTH / ADDR_WIDTH / LEN_WIDTH / 3 / 2  write address.
- m_axi_awlock / awcache / awprot / awqos  out  2 / 4 / 3 / 4  constant 0, 0011, 000, 0.
- m_axi_awvalid / awready  out / in  1  AW handshake.
- m_axi_wdata / wstrb / wlast  out  DATA_WIDTH / STRB_WIDTH / 1  write data; wstrb is all ones.
- m_axi_wvalid / wready  out / in  1  W handshake.
- m_axi_bid / bresp  in  ID_WIDTH / 2  response; bid is ignored.
- m_axi_bvalid / bready  in / out  1  B handshake.

## Operation
- Registers:
  - addr_reg: next burst address.
  - remain_reg: words not yet issued, CNT_WIDTH wide.
  - beat_reg: beats left in the current burst.
- State machine:
  - IDLE: cmd_ready=1. On accept, load addr_reg and remain_reg, and clear error.
    - cmd_len=0: go to FINISH.
    - Otherwise: go to ADDR.
  - ADDR: awvalid=1. Burst beats n = min(remain_reg, MAX_BURST_LEN, (4096 − addr_reg[11:0]) / STRB_WIDTH).
    - Drive awaddr=addr_reg, awlen=n−1, awsize=log2(STRB_WIDTH), awburst=01.
    - On AW handshake: beat_reg=n, remain_reg−=n, addr_reg+=n·STRB_WIDTH. Go to DATA.
  - DATA: pass-through, combinational.
    - wvalid=s_axis_tvalid, wdata=tdata, s_axis_tready=wready.
    - wlast = (beat_reg==1).
    - Each W handshake decrements beat_reg. The handshake on the last beat goes to RESP.
  - RESP: bready=1. On B handshake, OR (bresp≠00) into error.
    - remain_reg>0: go to ADDR.
    - remain_reg=0: go to FINISH.
  - FINISH: done=1 for exactly one cycle, then IDLE.
- Outside DATA: s_axis_tready=0 and wvalid=0. Stream words arriving early are held off, never dropped.
- Only one burst is outstanding at a time.
- All address arithmetic is modulo 2**ADDR_WIDTH.
- The 4 KB rule applies only to bits [11:0]. When ADDR_WIDTH<12, it degenerates to the address-space wrap.

## Timing
- Reset values:
  - cmd_ready=0, becoming 1 on the first cycle after rst deasserts.
  - awvalid=0, wvalid=0, s_axis_tready=0, bready=0.
  - busy=0, done=0, error=0.
- Command accepted at cycle T: awvalid=1 at T+1, busy=1 at T+1.
- AW handshake at T: W beats may complete from T+1, one per cycle at full throughput.
- Last W handshake at T: bready=1 from T+1.
- B handshake at T:
  - next awvalid at T+1, or done at T+1;
  - then busy=0 and cmd_ready=1 at T+2.
- cmd_len=0 accepted at T: done at T+1, with no AXI traffic.
- awvalid and all AW fields are held stable until awready.
- bready is never asserted outside RESP.
- Reset asserted mid-transfer: all outputs return to reset values on the next edge. The partial burst is abandoned; the downstream slave is reset together with this block.

## Test plan
- Single burst: cmd addr 0x0100, len 4, stream D0..D3, downstream AXI4 RAM → one AW: awaddr 0x0100, awlen 3, awsize 2. wlast on the 4th beat. Single done pulse. RAM word addresses 0x40..0x43 hold D0..D3.
- Multi-burst: addr 0x0000, len 40 → awlen 15, 15, 7 at 0x0000, 0x0040, 0x0080. 40 beats total. done only after the third B.
- 4 KB split: addr 0x0FF8, len 8, ADDR_WIDTH 16 → AW awlen 1 at 0x0FF8, then awlen 5 at 0x1000.
- Backpressure: random tvalid gaps, awready delayed 3 cycles, bready path stalled by bvalid delayed 5 cycles → no lost or duplicated beats. AW fields stable while waiting. done exactly once.
- Zero length and error:
  - len 0 → done at T+1, awvalid never asserted.
  - Injected bresp=10 on the second of two bursts → error=1 after done.
  - error clears on the next command accept.
- Reset mid-burst: rst for 1 cycle after 2 of 8 beats → all valids 0, cmd_ready=1 after release. A following len 3 command completes correctly.
